// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-file geometry and write-back entry type
// Purpose: XLEN / REG_AW constants and the queued write-back record.
// Ports: none (package).
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order pending-write queue with two push slots and one pop
// Purpose: holds write-back entries that could not go straight to the regfile port.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   push0_i, din0_i    oldest entry pushed this cycle
//   push1_i, din1_i    second entry pushed this cycle (only together with push0_i)
//   pop_i              drop the head entry
//   head_o             current head entry
//   count_o            entries currently held (0..DEPTH)
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0_i,
  input  wb_entry_t     din0_i,
  input  logic          push1_i,
  input  wb_entry_t     din1_i,
  input  logic          pop_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o
);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     wr_ptr1;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        n_push;

  // Pointers wrap naturally because DEPTH is a power of two; full vs empty
  // is told apart by count_q, never by pointer equality.
  always_comb begin
    n_push   = {1'b0, push0_i} + {1'b0, push1_i};
    wr_ptr1  = wr_ptr_q + PW'(1);
    wr_ptr_d = wr_ptr_q + PW'(n_push);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(n_push) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q] <= din0_i;
    if (push1_i) mem_q[wr_ptr1]  <= din1_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges ALU and LSU completions onto one regfile write port
// Purpose: at most one registered regfile write per cycle, in acceptance order (LSU older
//          than ALU in the same cycle), with collisions absorbed by wb_fifo.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU completion handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  load completion handshake
//   we, wa, wd                       registered regfile write port
//   q_count                          entries waiting in the queue
//   busy                             queue non-empty or a write on the port
module wb_write_arbiter
  import core_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              we,
  output logic [REG_AW-1:0] wa,
  output logic [XLEN-1:0]   wd,
  output logic [CW-1:0]     q_count,
  output logic              busy
);

  wb_entry_t         lsu_e, alu_e, head, out_e, din0, din1;
  logic              lsu_wr, alu_wr, q_empty;
  logic              push0, push1, pop, out_valid;
  logic              we_q, we_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic [XLEN-1:0]   wd_q, wd_d;

  // Ready depends only on the queue occupancy and lsu_valid. The slot freed
  // by a same-cycle pop is deliberately not counted, so two accepted writes
  // always fit without relying on the pop.
  assign lsu_ready = (q_count <= CW'(QDEPTH - 1));
  assign alu_ready = (q_count <= CW'(QDEPTH - 2)) |
                     ((q_count == CW'(QDEPTH - 1)) & ~lsu_valid);

  assign lsu_e = {lsu_rd, lsu_data};
  assign alu_e = {alu_rd, alu_data};

  // Writes to x0 are consumed by the handshake but never take a slot.
  assign lsu_wr  = lsu_valid & lsu_ready & (lsu_rd != '0);
  assign alu_wr  = alu_valid & alu_ready & (alu_rd != '0);
  assign q_empty = (q_count == '0);

  always_comb begin
    push0     = 1'b0;
    push1     = 1'b0;
    pop       = 1'b0;
    din0      = lsu_e;
    din1      = alu_e;
    out_valid = 1'b0;
    out_e     = head;
    if (q_empty) begin
      // Oldest accepted write bypasses the queue; a younger one waits.
      if (lsu_wr) begin
        out_valid = 1'b1;
        out_e     = lsu_e;
        if (alu_wr) begin
          push0 = 1'b1;
          din0  = alu_e;
        end
      end else if (alu_wr) begin
        out_valid = 1'b1;
        out_e     = alu_e;
      end
    end else begin
      // Head is older than anything arriving now, so everything new queues.
      pop       = 1'b1;
      out_valid = 1'b1;
      if (lsu_wr) begin
        push0 = 1'b1;
        din0  = lsu_e;
        push1 = alu_wr;
        din1  = alu_e;
      end else if (alu_wr) begin
        push0 = 1'b1;
        din0  = alu_e;
      end
    end
  end

  wb_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push0_i (push0),
    .din0_i  (din0),
    .push1_i (push1),
    .din1_i  (din1),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (q_count)
  );

  // wa/wd hold their last value on idle cycles.
  always_comb begin
    we_d = out_valid;
    wa_d = out_valid ? out_e.rd   : wa_q;
    wd_d = out_valid ? out_e.data : wd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign busy = (q_count != '0) | we_q;

endmodule
